ltc2195_spi_config: RTL and testbench

SPI configuration controller for the LTC2195 dual 16-bit ADC. After reset it programs the ADC's serial-mode registers A0–A4 with a fixed start-up sequence. It then accepts single-register read/write commands from host logic over a valid/ready handshake. It owns the `scs`/`sck`/`sdo`/`sdi` pins and sits beside the ADC datapath receiver, which waits on `init_done` before trusting DCO/FR/data lanes.

---
 rtl/ltc2195_spi_config.sv | 218 +++++++++++++++++++++
 tb/tb_ltc2195_spi_config.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2195_spi_config.sv
// LTC2195 serial-register programmer: fixed A0-A4 start-up sequence, then host SPI bridge.
// Optional feature macro: LTC2195_READBACK_EN (reads A1-A4 back after init, flags init_err).
module ltc2195_spi_config #(
  parameter int         CLK_DIV = 4,
  parameter int         CS_GAP  = 8,
  parameter logic [7:0] REG_A1  = 8'h00,
  parameter logic [7:0] REG_A2  = 8'h01,
  parameter logic [7:0] REG_A3  = 8'h00,
  parameter logic [7:0] REG_A4  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       init_err,
  output logic       busy,
  output logic       scs,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

`ifdef LTC2195_READBACK_EN
  localparam logic [3:0] LP_LAST = 4'd8;
`else
  localparam logic [3:0] LP_LAST = 4'd4;
`endif
  localparam logic [15:0] LP_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_GAP_LAST = 16'(CS_GAP - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic [15:0] r_shift;
  logic [7:0]  r_rx;
  logic [3:0]  r_idx;
  logic        r_host;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_init_done;
  logic [7:0]  r_rsp_rdata;
  logic        r_scs;
  logic        r_sck;

  logic        w_phase_end;
  logic        w_frame_end;
  logic        w_in_frame;
  logic [15:0] w_init_word;
  logic [15:0] w_load_word;
`ifdef LTC2195_READBACK_EN
  logic [7:0]  w_rb_exp;
`endif

  always_comb begin
    w_phase_end = 1'b0;
    unique case (r_state)
      S_SETUP, S_HIGH, S_LOW: w_phase_end = (r_cnt == LP_DIV_LAST);
      S_GAP:                  w_phase_end = (r_cnt == LP_GAP_LAST);
      default:                w_phase_end = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!r_init_done || cmd_valid) w_next = S_LOAD;
      S_LOAD:  w_next = S_SETUP;
      S_SETUP: if (w_phase_end) w_next = S_HIGH;
      S_HIGH:  if (w_phase_end) w_next = S_LOW;
      S_LOW: begin
        if (w_phase_end) w_next = (r_bit == 4'd0) ? S_GAP : S_HIGH;
      end
      S_GAP:   if (w_phase_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Start-up frames indexed by r_idx; readback frames follow A4 when enabled
  always_comb begin
    w_init_word = 16'h0080;
`ifdef LTC2195_READBACK_EN
    w_rb_exp = REG_A1;
`endif
    case (r_idx)
      4'd1: w_init_word = {8'h01, REG_A1};
      4'd2: w_init_word = {8'h02, REG_A2};
      4'd3: w_init_word = {8'h03, REG_A3};
      4'd4: w_init_word = {8'h04, REG_A4};
`ifdef LTC2195_READBACK_EN
      4'd5: w_init_word = 16'h8100;
      4'd6: begin
        w_init_word = 16'h8200;
        w_rb_exp    = REG_A2;
      end
      4'd7: begin
        w_init_word = 16'h8300;
        w_rb_exp    = REG_A3;
      end
      4'd8: begin
        w_init_word = 16'h8400;
        w_rb_exp    = REG_A4;
      end
`endif
      default: w_init_word = 16'h0080;
    endcase
  end

  assign w_load_word = r_host
    ? {r_rw, r_addr, (r_rw ? 8'h00 : r_wdata)}
    : w_init_word;

  assign w_frame_end = (r_state == S_GAP) && w_phase_end;
  assign w_in_frame  = (w_next == S_SETUP) ||
                       (w_next == S_HIGH)  ||
                       (w_next == S_LOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_idx       <= '0;
      r_host      <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_init_done <= 1'b0;
      r_rsp_rdata <= '0;
      r_scs       <= 1'b1;
      r_sck       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_scs   <= !w_in_frame;
      r_sck   <= (w_next == S_HIGH);

      if (w_phase_end || r_state == S_IDLE || r_state == S_LOAD)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;

      if (r_state == S_IDLE && w_next == S_LOAD) begin
        r_host <= r_init_done;
        if (r_init_done) begin
          r_rw    <= cmd_rw;
          r_addr  <= cmd_addr;
          r_wdata <= cmd_wdata;
        end
      end

      if (r_state == S_LOAD) begin
        r_shift <= w_load_word;
        r_bit   <= 4'd15;
      end

      // sdo advances as sck falls; sdi is taken just before it falls
      if (r_state == S_HIGH && w_phase_end) begin
        r_shift <= {r_shift[14:0], 1'b0};
        if (r_bit <= 4'd7) r_rx <= {r_rx[6:0], sdi};
      end

      if (r_state == S_LOW && w_phase_end)
        r_bit <= r_bit - 4'd1;

      if (r_state == S_LOW && w_next == S_GAP && r_host)
        r_rsp_rdata <= r_rw ? r_rx : 8'h00;

      if (w_frame_end && !r_host) begin
        if (r_idx == LP_LAST) r_init_done <= 1'b1;
        else                  r_idx <= r_idx + 4'd1;
      end
    end
  end

`ifdef LTC2195_READBACK_EN
  logic r_init_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_err <= 1'b0;
    end else if (w_frame_end && !r_host && r_idx >= 4'd5) begin
      if (r_rx != w_rb_exp) r_init_err <= 1'b1;
    end
  end

  assign init_err = r_init_err;
`else
  assign init_err = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE) && r_init_done;
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = w_frame_end && r_host;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;
  assign scs       = r_scs;
  assign sck       = r_sck;
  assign sdo       = r_shift[15];

endmodule

// File: tb/tb_ltc2195_spi_config.sv
// Bench for ltc2195_spi_config: SPI frame/response scoreboard with an LTC2195 register model.
// Honours LTC2195_READBACK_EN when the design is built with it.
module tb_ltc2195_spi_config;

`ifdef LTC2195_READBACK_EN
  localparam int   NINIT   = 9;
  localparam logic EXP_ERR = 1'b1;
`else
  localparam int   NINIT   = 5;
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       init_err;
  logic       busy;
  logic       scs;
  logic       sck;
  logic       sdo;
  logic       sdi = 1'b0;

  ltc2195_spi_config #(
    .CLK_DIV(2),
    .CS_GAP (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .init_err (init_err),
    .busy     (busy),
    .scs      (scs),
    .sck      (sck),
    .sdo      (sdo),
    .sdi      (sdi)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          frames = 0;
  int          rsp_seen = 0;
  int          lowc = 0;
  int          nb = 0;
  logic        mon_en = 1'b0;
  logic        p_sck = 1'b0;
  logic [15:0] sh = '0;
  logic [7:0]  tx = '0;
  logic [7:0]  rdb;
  logic [7:0]  tbl [0:127];
  logic [15:0] exp_w [$];
  logic [7:0]  exp_r [$];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ADC model: frame capture on sdo, read data on sdi, scs-low cycle count
  always @(negedge clk) begin
    if (scs === 1'b0) lowc++;
    else              lowc = 0;
    if (scs !== 1'b0) begin
      nb  = 0;
      sdi = 1'b0;
    end else if (sck && !p_sck) begin
      sh = {sh[14:0], sdo};
      nb++;
      if (nb == 8) begin
        rdb = sh[7] ? tbl[sh[6:0]] : 8'h00;
        sdi = rdb[7];
        tx  = {rdb[6:0], 1'b0};
      end
    end else if (!sck && p_sck && nb >= 9 && nb < 16) begin
      sdi = tx[7];
      tx  = {tx[6:0], 1'b0};
    end
    p_sck = sck;
  end

  always @(posedge scs) begin
    if (mon_en && !rst) begin
      frames++;
      chk("frame_pending", 16'(exp_w.size() != 0), 16'd1);
      if (exp_w.size() != 0) chk("frame_word", sh, exp_w.pop_front());
      chk("frame_len", 16'(lowc), 16'd66);
      chk("frame_sck", 16'(nb), 16'd16);
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst && rsp_valid) begin
      rsp_seen++;
      chk("rsp_pending", 16'(exp_r.size() != 0), 16'd1);
      if (exp_r.size() != 0) chk("rsp_rdata", {8'h00, rsp_rdata}, {8'h00, exp_r.pop_front()});
    end
  end

  task automatic push_init();
    exp_w.push_back(16'h0080);
    exp_w.push_back(16'h0100);
    exp_w.push_back(16'h0201);
    exp_w.push_back(16'h0300);
    exp_w.push_back(16'h0400);
`ifdef LTC2195_READBACK_EN
    exp_w.push_back(16'h8100);
    exp_w.push_back(16'h8200);
    exp_w.push_back(16'h8300);
    exp_w.push_back(16'h8400);
`endif
  endtask

  task automatic wait_rsp(input string tag, input int acc);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(cyc - acc), 16'd75);
    @(negedge clk);
  endtask

  task automatic send(input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] rd);
    int n = 0;
    int acc;
    exp_w.push_back({rw, a, (rw ? 8'h00 : d)});
    exp_r.push_back(rd);
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(rw ? "rd_lat" : "wr_lat", acc);
  endtask

  initial begin
    int   n;
    int   acc;
    int   f0;
    int   r0;
    logic early;

    for (int i = 0; i < 128; i++) tbl[i] = 8'h00;
    tbl[2] = 8'h01;
`ifdef LTC2195_READBACK_EN
    tbl[3] = 8'hFF;
`endif
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_outs", {8'h00, scs, sck, sdo, cmd_ready, rsp_valid,
                     init_done, init_err, busy}, 16'h0080);
    chk("rst_rdata", {8'h00, rsp_rdata}, 16'h0000);

    // host command raised while init is still running
    push_init();
    exp_w.push_back(16'h03A5);
    exp_r.push_back(8'h00);
    cmd_rw    = 1'b0;
    cmd_addr  = 7'h03;
    cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    mon_en    = 1'b1;
    f0        = frames;
    r0        = rsp_seen;
    rst       = 1'b0;
    @(negedge clk);
    chk("busy_start", busy, 1);
    early = 1'b0;
    n = 0;
    while (!init_done && n < 3000) begin
      if (cmd_ready) early = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("init_done", init_done, 1);
    chk("ready_held", early, 0);
    chk("init_frames", 16'(frames - f0), 16'(NINIT));
    chk("init_err", init_err, EXP_ERR);
    chk("no_init_rsp", 16'(rsp_seen - r0), 16'd0);
    chk("ready_up", cmd_ready, 1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_drop", cmd_ready, 0);
    wait_rsp("early_wr_lat", acc);
    chk("early_is_6th", 16'(frames - f0), 16'(NINIT + 1));

    tbl[2] = 8'h3C;
    send(1'b1, 7'h02, 8'h77, 8'h3C);
    send(1'b0, 7'h7F, 8'hFF, 8'h00);
    tbl[127] = 8'hA5;
    send(1'b1, 7'h7F, 8'h00, 8'hA5);

    // cmd_valid held across two back-to-back frames
    exp_w.push_back(16'h045A);
    exp_w.push_back(16'h04C3);
    exp_r.push_back(8'h00);
    exp_r.push_back(8'h00);
    r0 = rsp_seen;
    cmd_rw    = 1'b0;
    cmd_addr  = 7'h04;
    cmd_wdata = 8'h5A;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_wdata = 8'hC3;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_accept", cmd_ready, 1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("b2b_lat", acc);
    chk("b2b_rsps", 16'(rsp_seen - r0), 16'd2);

    // reset during bit 9 of the A2 frame
    tbl[2] = 8'h01;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_done", init_done, 0);
    f0 = frames;
    push_init();
    rst = 1'b0;
    n = 0;
    while (!((frames - f0) == 2 && nb >= 7) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_point", 16'(frames - f0), 16'd2);
    #2 rst = 1'b1;
    #1;
    chk("abort_pins", {13'h0, scs, sck, busy}, 16'h0004);
    exp_w.delete();
    push_init();
    repeat (2) @(negedge clk);
    f0  = frames;
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_done", init_done, 1);
    chk("reinit_frames", 16'(frames - f0), 16'(NINIT));
    chk("reinit_err", init_err, EXP_ERR);

    send(1'b0, 7'h01, 8'h3C, 8'h00);
    chk("exp_w_empty", 16'(exp_w.size()), 16'd0);
    chk("exp_r_empty", 16'(exp_r.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
